// File: rtl/score_pulse_scheduler.sv
// Buffers weighted hit events in a small FIFO and expands each into evenly spaced score pulses.
// Optional: define SCORE_COMBO_MULT_EN to double an event's pulses once the hit streak reaches COMBO_THRESH.
module score_pulse_scheduler #(
    parameter int POINT_W      = 4,
    parameter int DEPTH        = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int COMBO_THRESH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               song_start,
    input  logic               hit_valid,
    input  logic [POINT_W-1:0] hit_points,
    output logic               hit_ready,
    output logic               score_pulse,
    output logic               counter_reset,
    output logic [POINT_W:0]   pending,
    output logic               busy
);
    localparam int AW    = $clog2(DEPTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);
    localparam logic [POINT_W:0] PEND_ONE = (POINT_W+1)'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 0 ||
        COMBO_THRESH < 0 || COMBO_THRESH > 255) begin : g_bad_params
        $error("score_pulse_scheduler: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PULSE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic               full_q, full_d;
    logic [POINT_W:0]   pending_q, pending_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               score_pulse_q, score_pulse_d;
    logic               counter_reset_q, counter_reset_d;
    logic [POINT_W-1:0] mem_q [DEPTH];

    logic               empty;
    logic               push;
    logic               pop;
    logic [POINT_W-1:0] head_points;
    logic [POINT_W:0]   load_count;

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign head_points = mem_q[rd_ptr_q[AW-1:0]];
    // A hit offered alongside song_start is discarded along with the rest of the queue.
    assign push        = hit_valid && !full_q && !song_start;

`ifdef SCORE_COMBO_MULT_EN
    logic [7:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        if (pop) begin
            if (head_points == '0) begin
                streak_d = '0;
            end else if (streak_q != 8'hFF) begin
                streak_d = streak_q + 8'd1;
            end
        end
        if (song_start) begin
            streak_d = '0;
        end
    end

    // The streak seen before this pop decides whether the event is doubled.
    assign load_count = (streak_q >= 8'(COMBO_THRESH)) ? {head_points, 1'b0}
                                                       : {1'b0, head_points};

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign load_count = {1'b0, head_points};
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d         = state_q;
        pending_d       = pending_q;
        gap_cnt_d       = gap_cnt_q;
        score_pulse_d   = 1'b0;
        counter_reset_d = 1'b0;
        pop             = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pop       = 1'b1;
                pending_d = load_count;
                if (load_count != '0) begin
                    state_d       = S_PULSE;
                    score_pulse_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PULSE: begin
                pending_d = pending_q - PEND_ONE;
                if (pending_q == PEND_ONE) begin
                    state_d = S_IDLE;
                end else if (GAP_CYCLES == 0) begin
                    state_d       = S_PULSE;
                    score_pulse_d = 1'b1;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LAST;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d       = S_PULSE;
                    score_pulse_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

        if (song_start) begin
            state_d         = S_IDLE;
            pending_d       = '0;
            gap_cnt_d       = '0;
            score_pulse_d   = 1'b0;
            counter_reset_d = 1'b1;
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            full_d          = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            full_q          <= 1'b0;
            pending_q       <= '0;
            gap_cnt_q       <= '0;
            score_pulse_q   <= 1'b0;
            counter_reset_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            full_q          <= full_d;
            pending_q       <= pending_d;
            gap_cnt_q       <= gap_cnt_d;
            score_pulse_q   <= score_pulse_d;
            counter_reset_q <= counter_reset_d;
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= hit_points;
        end
    end

    assign hit_ready     = !full_q;
    assign score_pulse   = score_pulse_q;
    assign counter_reset = counter_reset_q;
    assign pending       = pending_q;
    assign busy          = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_score_pulse_scheduler.sv
// Self-checking bench for score_pulse_scheduler: directed vectors, corner sequences and a
// randomized run against a timeline model of when each accepted event is loaded and pulsed.
module tb_score_pulse_scheduler;
    localparam int POINT_W      = 4;
    localparam int DEPTH        = 4;
    localparam int GAP_CYCLES   = 2;
    localparam int COMBO_THRESH = 2;
    localparam int NRAND        = 1500;
    localparam int NDRAIN       = 400;
    localparam int MAXC         = 2600;

    logic               clk = 1'b0;
    logic               reset;
    logic               song_start;
    logic               hit_valid;
    logic [POINT_W-1:0] hit_points;
    logic               hit_ready;
    logic               score_pulse;
    logic               counter_reset;
    logic [POINT_W:0]   pending;
    logic               busy;

    int checks = 0;
    int errors = 0;

    score_pulse_scheduler #(
        .POINT_W     (POINT_W),
        .DEPTH       (DEPTH),
        .GAP_CYCLES  (GAP_CYCLES),
        .COMBO_THRESH(COMBO_THRESH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .song_start   (song_start),
        .hit_valid    (hit_valid),
        .hit_points   (hit_points),
        .hit_ready    (hit_ready),
        .score_pulse  (score_pulse),
        .counter_reset(counter_reset),
        .pending      (pending),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int points;
        int n_pulses;
        int first;
        int last;
        int idle;
    } vec_t;

    vec_t vecs [5];

    bit exp_pulse [MAXC];
    bit exp_cr    [MAXC];
    int exp_pend  [MAXC];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Leaves the bench #1 after the first edge with reset released; that cycle is cycle 0.
    task automatic do_reset();
        reset      = 1'b1;
        song_start = 1'b0;
        hit_valid  = 1'b0;
        hit_points = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic hit_once(input int p, input bit with_song, output bit accepted, output bit pulsed);
        hit_valid  = 1'b1;
        hit_points = POINT_W'(p);
        song_start = with_song;
        @(negedge clk);
        accepted = hit_ready && !with_song;
        pulsed   = score_pulse;
        @(posedge clk);
        #1;
        hit_valid  = 1'b0;
        song_start = 1'b0;
    endtask

    // Offsets count from the cycle before the watch starts (the handshake cycle for single events).
    task automatic watch(input int n, output int pulses, output int crs,
                         output int first, output int last, output int idle);
        pulses = 0;
        crs    = 0;
        first  = -1;
        last   = -1;
        idle   = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (score_pulse) begin
                pulses++;
                if (first < 0) first = i;
                last = i;
            end
            if (counter_reset) crs++;
            if (!busy && idle < 0) idle = i;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int  pulses, crs, first, last, idle, acc, low, seen, total, s, cnt, p, t, d, streak, idle_at;
        bit  a, pl, v, ss, exp_ready;
        int  pop_q[$];

        vecs[0] = '{0,  0,  -1, -1, 3};
        vecs[1] = '{1,  1,  3,  3,  4};
        vecs[2] = '{3,  3,  3,  9,  10};
        vecs[3] = '{7,  7,  3,  21, 22};
        vecs[4] = '{15, 15, 3,  45, 46};

        // Reset values.
        do_reset();
        @(negedge clk);
        check("reset_hit_ready", int'(hit_ready), 1);
        check("reset_score_pulse", int'(score_pulse), 0);
        check("reset_counter_reset", int'(counter_reset), 0);
        check("reset_pending", int'(pending), 0);
        check("reset_busy", int'(busy), 0);

        // Single events from a clean reset: count, first/last pulse offset, busy fall.
        for (int k = 0; k < 5; k++) begin
            do_reset();
            hit_once(vecs[k].points, 1'b0, a, pl);
            watch(60, pulses, crs, first, last, idle);
            check($sformatf("vec%0d_pulses", k), pulses, vecs[k].n_pulses);
            check($sformatf("vec%0d_first", k), first, vecs[k].first);
            check($sformatf("vec%0d_last", k), last, vecs[k].last);
            check($sformatf("vec%0d_idle", k), idle, vecs[k].idle);
        end

        // Pending walks 3,2,1 on the pulse cycles and ends at 0.
        do_reset();
        hit_once(3, 1'b0, a, pl);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (score_pulse) begin
                check($sformatf("pend_at_pulse%0d", seen), int'(pending), 3 - seen);
                seen++;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("pend_final", int'(pending), 0);
        check("pend_pulse_count", seen, 3);

        // Miss followed by a 2-point hit.
        do_reset();
        total = 0;
        hit_once(0, 1'b0, a, pl);
        total += int'(pl);
        hit_once(2, 1'b0, a, pl);
        total += int'(pl);
        watch(40, pulses, crs, first, last, idle);
        check("miss_then_two_pulses", total + pulses, 2);
        check("miss_then_two_idle", int'(busy), 0);

        // Backpressure: offer 1-point hits for 8 consecutive cycles.
        do_reset();
        acc = 0; low = 0; total = 0;
        hit_valid  = 1'b1;
        hit_points = POINT_W'(1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (hit_ready) acc++;
            else low++;
            if (score_pulse) total++;
            @(posedge clk);
            #1;
        end
        hit_valid = 1'b0;
        watch(80, pulses, crs, first, last, idle);
        check("bp_accepted", acc, 6);
        check("bp_ready_low_cycles", low, 2);
`ifdef SCORE_COMBO_MULT_EN
        check("bp_total_pulses", total + pulses, 10);
`else
        check("bp_total_pulses", total + pulses, 6);
`endif

        // song_start in the middle of a 15-pulse burst.
        do_reset();
        hit_once(15, 1'b0, a, pl);
        seen = 0;
        for (int i = 0; i < 60 && seen < 5; i++) begin
            @(negedge clk);
            if (score_pulse) seen++;
            @(posedge clk);
            #1;
        end
        check("ss_pulses_before", seen, 5);
        song_start = 1'b1;
        @(posedge clk);
        #1 song_start = 1'b0;
        watch(60, pulses, crs, first, last, idle);
        check("ss_counter_reset_cycles", crs, 1);
        check("ss_first_counter_reset", first, -1);
        check("ss_pulses_after", pulses, 0);
        @(negedge clk);
        check("ss_busy", int'(busy), 0);
        check("ss_pending", int'(pending), 0);
        check("ss_hit_ready", int'(hit_ready), 1);

        // reset in the middle of a burst clears everything without counter_reset.
        do_reset();
        hit_once(15, 1'b0, a, pl);
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(negedge clk);
            if (score_pulse) seen++;
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        watch(60, pulses, crs, first, last, idle);
        check("rst_mid_counter_reset", crs, 0);
        check("rst_mid_pulses", pulses, 0);
        @(negedge clk);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_pending", int'(pending), 0);

        // song_start and a hit in the same cycle: the hit is dropped.
        do_reset();
        hit_once(4, 1'b1, a, pl);
        watch(30, pulses, crs, first, last, idle);
        check("simul_pulses", pulses, 0);
        check("simul_counter_reset", crs, 1);
        check("simul_busy", int'(busy), 0);

        // Streak sequence 1,1,1,0,1.
        do_reset();
        acc = 0; total = 0;
        foreach (vecs[k]) begin end
        for (int k = 0; k < 5; k++) begin
            hit_once((k == 3) ? 0 : 1, 1'b0, a, pl);
            acc   += int'(a);
            total += int'(pl);
        end
        watch(80, pulses, crs, first, last, idle);
        check("combo_accepted", acc, 5);
`ifdef SCORE_COMBO_MULT_EN
        check("combo_total_pulses", total + pulses, 5);
`else
        check("combo_total_pulses", total + pulses, 4);
`endif

        // Randomized run against the event timeline model.
        do_reset();
        idle_at = 0;
        streak  = 0;
        pop_q.delete();
        for (int c = 0; c < NRAND + NDRAIN; c++) begin
            while (pop_q.size() > 0 && pop_q[0] < c) void'(pop_q.pop_front());
            exp_ready = (pop_q.size() < DEPTH);

            v  = (c < NRAND) && ($urandom_range(0, 1) == 1);
            ss = (c < NRAND) && ($urandom_range(0, 199) == 0);
            p  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            hit_valid  = v;
            song_start = ss;
            hit_points = POINT_W'(p);

            if (ss) begin
                for (int k = c + 1; k < MAXC; k++) begin
                    exp_pulse[k] = 1'b0;
                    exp_pend[k]  = 0;
                end
                exp_cr[c+1] = 1'b1;
                pop_q.delete();
                idle_at = c + 1;
                streak  = 0;
            end else if (v && exp_ready) begin
                s   = (c + 1 > idle_at) ? c + 1 : idle_at;
                cnt = p;
`ifdef SCORE_COMBO_MULT_EN
                if (p != 0) begin
                    if (streak >= COMBO_THRESH) cnt = 2 * p;
                    if (streak < 255) streak++;
                end else begin
                    streak = 0;
                end
`endif
                pop_q.push_back(s + 1);
                if (cnt == 0) begin
                    idle_at = s + 2;
                end else begin
                    last = s + 2 + (cnt - 1) * (GAP_CYCLES + 1);
                    for (t = s + 2; t <= last && t < MAXC; t++) begin
                        d = t - (s + 2);
                        exp_pulse[t] = ((d % (GAP_CYCLES + 1)) == 0);
                        exp_pend[t]  = cnt - d / (GAP_CYCLES + 1) - (((d % (GAP_CYCLES + 1)) != 0) ? 1 : 0);
                    end
                    idle_at = last + 1;
                end
            end

            @(negedge clk);
            check($sformatf("rnd_pulse_c%0d", c), int'(score_pulse), int'(exp_pulse[c]));
            check($sformatf("rnd_ready_c%0d", c), int'(hit_ready), int'(exp_ready));
            check($sformatf("rnd_pending_c%0d", c), int'(pending), exp_pend[c]);
            check($sformatf("rnd_cr_c%0d", c), int'(counter_reset), int'(exp_cr[c]));
            @(posedge clk);
            #1;
        end
        hit_valid  = 1'b0;
        song_start = 1'b0;
        @(negedge clk);
        check("rnd_final_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
